// File: rtl/mem_arbiter.sv
// Shares one fixed-latency word SRAM between instruction fetch and data load/store; data port wins.
// Optional stall/conflict statistics counters are enabled with `define ARB_STATS_EN.
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ready,
  output logic              stall,
`ifdef ARB_STATS_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       conflict_cnt,
`endif
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  typedef enum logic {OWN_DATA, OWN_INSTR} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              d_req;

  // Only the word-address slice of the byte addresses reaches the SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                              d_addr[31:ADDR_W+2], d_addr[1:0]};

  assign d_req = d_read | d_write;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (d_req) begin
          state_d = ACCESS;
          owner_d = OWN_DATA;
          addr_d  = d_addr[ADDR_W+1:2];
          wdata_d = d_wdata;
          we_d    = d_write;
          cnt_d   = '0;
        end else if (i_req) begin
          state_d = ACCESS;
          owner_d = OWN_INSTR;
          addr_d  = i_addr[ADDR_W+1:2];
          we_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(WAIT_CYCLES)) begin
          state_d = DONE;
          if (owner_q == OWN_INSTR) begin
            i_rdata_d = sram_rdata;
          end else if (!we_q) begin
            d_rdata_d = sram_rdata;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_DATA;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign sram_en    = (state_q == ACCESS);
  assign sram_we    = sram_en & we_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign i_ready    = (state_q == DONE) && (owner_q == OWN_INSTR);
  assign d_ready    = (state_q == DONE) && (owner_q == OWN_DATA);
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;
  // Drops in the ready cycle so the owning stage can advance.
  assign stall      = (i_req & ~i_ready) | (d_req & ~d_ready);

`ifdef ARB_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    stall_cnt_d    = stall_cnt_q;
    conflict_cnt_d = conflict_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if ((state_q == IDLE) && i_req && d_req && (conflict_cnt_q != '1)) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a behavioural SRAM and arbitration model.
// Stats outputs are checked when ARB_STATS_EN is defined.
module tb_mem_arbiter;
  localparam int unsigned W  = 2;
  localparam int unsigned AW = 16;

  logic        clk, rst;
  logic        i_req, i_ready, d_read, d_write, d_ready, stall;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic        sram_en, sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
`ifdef ARB_STATS_EN
  logic [31:0] stall_cnt, conflict_cnt;
`endif

  mem_arbiter #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .stall(stall),
`ifdef ARB_STATS_EN
    .stall_cnt(stall_cnt), .conflict_cnt(conflict_cnt),
`endif
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int unsigned w);
    return (w * 32'h9E3779B9) ^ 32'h5A5A0F0F;
  endfunction

  // Behavioural SRAM: unwritten words read back their initial pattern.
  logic [31:0] sram_mem [0:65535];
  bit          sram_written [0:65535];
  always @(posedge clk) begin
    if (sram_en && sram_we) begin
      sram_mem[sram_addr]     <= sram_wdata;
      sram_written[sram_addr] <= 1'b1;
    end
  end
  assign sram_rdata = !sram_en ? 32'hBAD0BAD0 :
                      sram_written[sram_addr] ? sram_mem[sram_addr] : init_word(32'(sram_addr));

  // Reference memory contents as seen by the pipeline.
  logic [31:0] model_mem [int unsigned];
  function automatic logic [31:0] model_read(input int unsigned w);
    return model_mem.exists(w) ? model_mem[w] : init_word(w);
  endfunction

  int vectors = 0;
  int miscompares = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { bit instr; int cyc; logic [31:0] data; } exp_t;
  exp_t sb[$];
  bit   mon_en = 1'b0;
  int   exp_stall_cnt = 0;
  int   exp_conflicts = 0;
  logic [31:0] cur_i = '0, cur_d = '0;

  // Monitor: pops the expectation due this cycle and checks handshake, stall and read data.
  always @(negedge clk) begin
    if (mon_en) begin
      bit ei, ed, es;
      ei = 1'b0; ed = 1'b0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        exp_t e;
        e = sb.pop_front();
        if (e.instr) begin ei = 1'b1; cur_i = e.data; end
        else         begin ed = 1'b1; cur_d = e.data; end
      end
      es = (i_req & ~ei) | ((d_read | d_write) & ~ed);
      if (es) exp_stall_cnt++;
      check("ready_stall", {29'd0, i_ready, d_ready, stall}, {29'd0, ei, ed, es});
      check("i_rdata", i_rdata, cur_i);
      check("d_rdata", d_rdata, cur_d);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic directed_store(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] old_d);
    d_write = 1'b1; d_addr = a; d_wdata = wd;
    @(negedge clk); check("st_stall0", {31'd0, stall}, 32'd1);
    for (int unsigned k = 1; k <= W + 1; k++) begin
      step(); @(negedge clk);
      check("st_access", {13'd0, sram_en, sram_we, d_ready, sram_addr}, {13'd0, 3'b110, a[AW+1:2]});
      check("st_wdata", sram_wdata, wd);
    end
    step(); @(negedge clk);
    check("st_ready", {30'd0, d_ready, stall}, 32'd2);
    check("st_rdata", d_rdata, old_d);
    model_mem[a[AW+1:2]] = wd;
    step(); d_write = 1'b0;
  endtask

  task automatic directed_fetch(input logic [31:0] a, input logic [31:0] exp_d, input bit abort);
    i_req = 1'b1; i_addr = a;
    for (int unsigned k = 1; k <= W + 1; k++) begin
      step();
      if (abort && k == 2) i_req = 1'b0;
      @(negedge clk);
      check("f_access", {13'd0, sram_en, sram_we, i_ready, sram_addr}, {13'd0, 3'b100, a[AW+1:2]});
    end
    step(); @(negedge clk);
    check("f_ready", {30'd0, i_ready, d_ready}, 32'd2);
    check("f_rdata", i_rdata, exp_d);
    step(); i_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); check("f_no_regrant", {31'd0, sram_en}, 32'd0);
      step();
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] w;
    w = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 31)) : 32'($urandom_range(0, 65535));
    return ($urandom() & 32'hFFFC0000) | (w << 2);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] last_load;
    rst = 1'b1; i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_outputs", {26'd0, sram_en, sram_we, i_ready, d_ready, stall, 1'b0}, 32'd0);
    check("rst_addr", {16'd0, sram_addr}, 32'd0);
    check("rst_rdata", i_rdata | d_rdata | sram_wdata, 32'd0);
    step();

    directed_store(32'h0000_0400, 32'hDEADBEEF, 32'd0);
    directed_store(32'h0000_0010, 32'hE3A01005, 32'd0);
    directed_fetch(32'h0000_0010, 32'hE3A01005, 1'b0);
    directed_fetch(32'h0000_0400, 32'hDEADBEEF, 1'b1);

    // Reset in the middle of a fetch clears everything, including captured data.
    i_req = 1'b1; i_addr = 32'h0000_0400;
    step(); step();
    rst = 1'b1; i_req = 1'b0;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", {27'd0, sram_en, sram_we, i_ready, d_ready, stall}, 32'd0);
    check("rst_mid_i_rdata", i_rdata, 32'd0);
    check("rst_mid_d_rdata", d_rdata, 32'd0);
    check("rst_mid_addr", {16'd0, sram_addr}, 32'd0);
    step();

    mon_en = 1'b1;
    last_load = '0;
    for (int r = 0; r < 150; r++) begin
      int kind, c, rd, rf, last, drop_at;
      bit has_f, has_d;
      logic [31:0] fa, da, wd;
      kind = $urandom_range(0, 5);
      has_f = (kind == 0) || (kind == 3) || (kind == 4);
      has_d = (kind != 0);
      fa = rand_addr();
      da = ($urandom_range(0, 3) == 0) ? fa : rand_addr();
      wd = $urandom();
      c = cyc; rd = 0; rf = 0;
      if (has_d) begin
        rd = c + W + 2;
        d_addr = da; d_wdata = wd;
        d_read  = (kind == 1) || (kind == 3) || (kind == 5);
        d_write = (kind == 2) || (kind == 4) || (kind == 5);
        if (d_write) model_mem[da[AW+1:2]] = wd;
        else last_load = model_read(da[AW+1:2]);
        sb.push_back('{instr: 1'b0, cyc: rd, data: last_load});
      end
      if (has_f) begin
        rf = has_d ? rd + W + 3 : c + W + 2;
        i_req = 1'b1; i_addr = fa;
        sb.push_back('{instr: 1'b1, cyc: rf, data: model_read(fa[AW+1:2])});
      end
      if (has_f && has_d) exp_conflicts++;
      last = has_f ? rf : rd;
      drop_at = (!(has_f && has_d) && $urandom_range(0, 2) == 0) ? c + 1 + $urandom_range(0, W) : -1;
      while (cyc <= last) begin
        step();
        if (cyc == rd + 1 || cyc == drop_at) begin d_read = 1'b0; d_write = 1'b0; end
        if (cyc == rf + 1 || cyc == drop_at) i_req = 1'b0;
      end
      repeat ($urandom_range(0, 2)) step();
    end
    repeat (4) step();
    check("scoreboard_drained", sb.size(), 32'd0);
`ifdef ARB_STATS_EN
    @(negedge clk);
    check("stall_cnt", stall_cnt, 32'(exp_stall_cnt));
    check("conflict_cnt", conflict_cnt, 32'(exp_conflicts));
`endif
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
